dmux_router: RTL and testbench
==============================

DMUX_ROUTER -- requirements
Module: dmux_router

Interface
REQ-001 Parameter WIDTH, default 16: data width of the input and of each output channel, in bits.
REQ-002 Parameter NCH, default 4: number of output channels; legal range 2..16.
REQ-003 Parameter SEL_W, default 2: width of the channel select; NCH SHALL be <= 2**SEL_W.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 in_data  input  WIDTH: payload to route.
REQ-007 in_sel  input  SEL_W: destination channel index for a unicast transfer.
REQ-008 in_bcast  input  1: 1 = broadcast to all channels; in_sel is ignored.
REQ-009 in_valid  input  1: the producer offers in_data, in_sel and in_bcast.
REQ-010 in_ready  output  1: the router accepts the offer this cycle.
REQ-011 out_data  output  NCH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 out_valid  output  NCH: channel k holds valid data.
REQ-013 out_ready  input  NCH: consumer k accepts the data on channel k.
REQ-014 err_sel  output  1: one-cycle pulse marking a dropped transfer with an out-of-range select.

Function
REQ-015 Each channel SHALL have a single-entry output register with two states, EMPTY and FULL; out_valid[k] = 1 exactly when channel k is FULL.
REQ-016 Transfers follow valid/ready rules: an input transfer occurs when in_valid & in_ready; an output transfer on k occurs when out_valid[k] & out_ready[k].
REQ-017 can_load[k] = EMPTY[k] | out_ready[k], so a FULL channel being drained this cycle can accept new data in the same cycle.
REQ-018 Unicast with in_sel < NCH: in_ready = can_load[in_sel]; in_ready SHALL NOT depend on the other channels.
REQ-019 Broadcast: in_ready = AND of can_load[k] over all k; the transfer is all-or-nothing.
REQ-020 Unicast with in_sel >= NCH: in_ready = 1; the data is discarded, no channel changes, and err_sel = 1 on the following cycle only.
REQ-021 in_ready is combinational from in_sel, in_bcast and out_ready, and SHALL NOT depend on in_valid.
REQ-022 Latency: data accepted at edge n appears on out_data with out_valid at edge n+1, i.e. one cycle.
REQ-023 Load and drain together on channel k: the register takes the new data and stays FULL (full throughput, 1 word/cycle/channel).
REQ-024 Drain with no load: FULL -> EMPTY; out_data[k] holds its last value (don't-care for checking).
REQ-025 A FULL channel whose out_ready is low SHALL hold out_data and out_valid stable until it is drained.
REQ-026 Channels are independent; a stalled channel SHALL NOT block unicast traffic to other channels.
REQ-027 Ordering: the words on each channel SHALL leave in the order they were accepted; there is no reordering or duplication.
REQ-028 in_data/in_sel/in_bcast are sampled only when a transfer occurs; no internal state changes when in_valid = 0.

Reset
REQ-029 While rst = 1 at an edge: every channel -> EMPTY, out_valid = 0, out_data = 0, err_sel = 0.
REQ-030 Reset during a transfer SHALL discard both in-flight and buffered data; no word accepted in the reset cycle is delivered.
REQ-031 in_ready SHALL still follow REQ-018..020 during reset (all channels are EMPTY after the first reset edge); producers must not rely on transfers made during reset.

Verification
REQ-032 After reset, unicast in_sel=2, in_data=16'hBEEF, out_ready=4'b0000 -> at the next edge out_valid=4'b0100 and channel 2 = BEEF; a second offer to sel 2 sees in_ready=0.
REQ-033 Channel 1 FULL with out_ready[1]=1, offer 16'h1234 to sel 1 in the same cycle -> in_ready=1, channel 1 = 1234 next cycle, out_valid[1] stays 1; streaming 8 words gives 8 outputs in order at 1/cycle.
REQ-034 Broadcast 16'hA5A5 with channel 3 FULL and out_ready[3]=0 -> in_ready=0 and no channel changes; raising out_ready[3] -> transfer, all 4 out_valid=1 with A5A5.
REQ-035 NCH=3, SEL_W=2, unicast in_sel=3 -> in_ready=1, err_sel=1 for exactly one cycle, out_valid unchanged.
REQ-036 Channel 0 stalled FULL while 16 words go to channels 1..3 -> all 16 are delivered and channel 0 data is unchanged.
REQ-037 rst asserted with all channels FULL and a transfer in progress -> next cycle out_valid=0, out_data=0, err_sel=0.

Source files
------------

// File: rtl/dmux_router.sv
// Valid/ready demultiplexer. Each accepted word goes to one output channel (or to all
// of them on broadcast). Each channel has a single-entry register. Out-of-range selects are dropped and flagged.
module dmux_router #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SEL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic                 in_bcast,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic                 err_sel
);
   localparam int unsigned NSEL = 1 << SEL_W;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

   // Per-select legality table; avoids a constant compare when NCH == 2**SEL_W.
   function automatic logic [NSEL-1:0] sel_ok_mask();
      logic [NSEL-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < NSEL; i++) m[i] = (i < NCH);
      return m;
   endfunction

   localparam logic [NSEL-1:0] SEL_OK = sel_ok_mask();

   ch_state_t        state_q [NCH];
   ch_state_t        state_d [NCH];
   logic [WIDTH-1:0] data_q  [NCH];
   logic [WIDTH-1:0] data_d  [NCH];
   logic [NSEL-1:0]  can_load;
   logic [NCH-1:0]   load;
   logic             sel_ok;
   logic             accept;
   logic             err_d;

   // Next-state, handshake and per-channel load decode.
   always_comb begin
      can_load = '0;
      load     = '0;
      in_ready = 1'b0;
      accept   = 1'b0;
      err_d    = 1'b0;
      sel_ok   = SEL_OK[in_sel];
      for (int unsigned k = 0; k < NCH; k++) begin
         state_d[k]  = state_q[k];
         data_d[k]   = data_q[k];
         can_load[k] = (state_q[k] == EMPTY) | out_ready[k];
      end

      if (in_bcast)    in_ready = &can_load[NCH-1:0];
      else if (sel_ok) in_ready = can_load[in_sel];
      else             in_ready = 1'b1;

      accept = in_valid & in_ready;
      err_d  = accept & ~in_bcast & ~sel_ok;

      for (int unsigned k = 0; k < NCH; k++) begin
         load[k] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
         if (load[k]) begin
            state_d[k] = FULL;
            data_d[k]  = in_data;
         end else if (out_ready[k]) begin
            state_d[k] = EMPTY;
         end
      end
   end

   // Reset overrides any transfer in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NCH; k++) begin
            state_q[k] <= EMPTY;
            data_q[k]  <= '0;
         end
         err_sel <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NCH; k++) begin
            state_q[k] <= state_d[k];
            data_q[k]  <= data_d[k];
         end
         err_sel <= err_d;
      end
   end

   always_comb begin
      out_valid = '0;
      out_data  = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         out_valid[k]                = (state_q[k] == FULL);
         out_data[k*WIDTH +: WIDTH]  = data_q[k];
      end
   end
endmodule

// File: tb/tb_dmux_router.sv
// Bench for dmux_router: directed scenarios plus random traffic, scored against
// per-channel queues of accepted words.
module tb_dmux_router;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic        in_bcast, in_valid, in_ready;
   logic [63:0] out_data;
   logic [3:0]  out_valid, out_ready;
   logic        err_sel;

   logic        rst3;
   logic [15:0] d3;
   logic [1:0]  s3;
   logic        b3, v3, r3, e3;
   logic [47:0] od3;
   logic [2:0]  ov3, or3;

   dmux_router #(.WIDTH(16), .NCH(4), .SEL_W(2)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel));

   dmux_router #(.WIDTH(16), .NCH(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst3), .in_data(d3), .in_sel(s3), .in_bcast(b3),
      .in_valid(v3), .in_ready(r3), .out_data(od3),
      .out_valid(ov3), .out_ready(or3), .err_sel(e3));

   int          checks = 0;
   int          failures = 0;
   logic [15:0] q [4][$];
   int          delivered [4];
   bit          last_acc;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // A channel can take a word if it is empty or being drained this cycle.
   function automatic bit exp_ready();
      bit r;
      r = 1'b1;
      if (in_bcast) begin
         for (int k = 0; k < 4; k++)
            if (q[k].size() != 0 && !out_ready[k]) r = 1'b0;
      end else begin
         r = (q[in_sel].size() == 0) || out_ready[in_sel];
      end
      return r;
   endfunction

   task automatic drive(bit v, logic [1:0] s, bit b, logic [15:0] d, logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_bcast  = b;
      in_data   = d;
      out_ready = r;
   endtask

   // One clock: check handshake, advance the model, check the outputs.
   task automatic tick();
      bit er;
      @(negedge clk);
      er = exp_ready();
      check("in_ready", 64'(in_ready), 64'(er));
      @(posedge clk);
      last_acc = in_valid && er;
      if (rst) begin
         for (int k = 0; k < 4; k++) q[k].delete();
      end else begin
         for (int k = 0; k < 4; k++)
            if (q[k].size() != 0 && out_ready[k]) begin
               void'(q[k].pop_front());
               delivered[k]++;
            end
         if (last_acc)
            for (int k = 0; k < 4; k++)
               if (in_bcast || in_sel == 2'(k)) q[k].push_back(in_data);
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
         if (q[k].size() != 0)
            check($sformatf("out_data[%0d]", k), 64'(out_data[k*16 +: 16]), 64'(q[k][0]));
      end
      check("err_sel", 64'(err_sel), 64'(0));
   endtask

   initial begin
      int base, sent, guard;
      rst = 1'b1;
      drive(0, 2'd0, 0, 16'h0, 4'h0);
      rst3 = 1'b1; v3 = 1'b0; s3 = 2'd0; b3 = 1'b0; d3 = 16'h0; or3 = 3'b000;
      for (int k = 0; k < 4; k++) delivered[k] = 0;
      @(posedge clk); #1;
      tick();
      check("rst_out_data", out_data, 64'h0);
      check("rst_out_valid", 64'(out_valid), 64'h0);

      // Unicast into a stalled channel, then a blocked second offer.
      rst = 1'b0;
      drive(1, 2'd2, 0, 16'hBEEF, 4'b0000);
      tick();
      check("beef_valid", 64'(out_valid), 64'h4);
      check("beef_data", 64'(out_data[47:32]), 64'hBEEF);
      drive(1, 2'd2, 0, 16'hCAFE, 4'b0000);
      #1 check("beef_second_ready", 64'(in_ready), 64'h0);
      tick();

      // Load-while-drain and an 8-word stream at full rate.
      drive(0, 2'd0, 0, 16'h0, 4'hF); tick();
      drive(1, 2'd1, 0, 16'h1111, 4'h0); tick();
      drive(1, 2'd1, 0, 16'h1234, 4'b0010);
      #1 check("ld_drain_ready", 64'(in_ready), 64'h1);
      tick();
      check("ld_drain_data", 64'(out_data[31:16]), 64'h1234);
      check("ld_drain_valid", 64'(out_valid[1]), 64'h1);
      base = delivered[1];
      for (int i = 0; i < 8; i++) begin
         drive(1, 2'd1, 0, 16'(16'h5000 + i), 4'b0010);
         tick();
         check("stream_accept", 64'(last_acc), 64'h1);
      end
      drive(0, 2'd0, 0, 16'h0, 4'b0010); tick();
      check("stream_count", 64'(delivered[1] - base), 64'd9);

      // Broadcast blocked by one stalled full channel, then released.
      drive(0, 2'd0, 0, 16'h0, 4'hF); tick();
      drive(1, 2'd3, 0, 16'h0333, 4'h0); tick();
      drive(1, 2'd0, 1, 16'hA5A5, 4'b0111);
      #1 check("bcast_blocked", 64'(in_ready), 64'h0);
      tick();
      check("bcast_nochange", 64'(out_valid), 64'h8);
      drive(1, 2'd0, 1, 16'hA5A5, 4'b1111);
      #1 check("bcast_ready", 64'(in_ready), 64'h1);
      tick();
      check("bcast_valid", 64'(out_valid), 64'hF);
      check("bcast_data", out_data, 64'hA5A5_A5A5_A5A5_A5A5);

      // Channel 0 stalled while 16 words flow to channels 1..3.
      drive(0, 2'd0, 0, 16'h0, 4'hF); tick();
      drive(1, 2'd0, 0, 16'h0C0C, 4'h0); tick();
      base = delivered[1] + delivered[2] + delivered[3];
      sent = 0; guard = 0;
      while (sent < 16 && guard < 300) begin
         drive(1, 2'($urandom_range(1, 3)), 0, 16'($urandom), {3'($urandom), 1'b0});
         tick();
         if (last_acc) sent++;
         guard++;
      end
      check("stall_sent", 64'(sent), 64'd16);
      drive(0, 2'd0, 0, 16'h0, 4'b1110); tick(); tick();
      check("stall_delivered", 64'(delivered[1] + delivered[2] + delivered[3] - base), 64'd16);
      check("stall_ch0_valid", 64'(out_valid[0]), 64'h1);
      check("stall_ch0_data", 64'(out_data[15:0]), 64'h0C0C);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         drive(($urandom % 4) != 0, 2'($urandom), ($urandom % 8) == 0, 16'($urandom), 4'($urandom));
         tick();
      end
      rst = 1'b0;

      // Reset with every channel full and a transfer offered.
      drive(0, 2'd0, 0, 16'h0, 4'hF); tick();
      drive(1, 2'd0, 1, 16'h7777, 4'h0); tick();
      check("pre_rst_full", 64'(out_valid), 64'hF);
      rst = 1'b1;
      drive(1, 2'd1, 0, 16'h8888, 4'hF);
      tick();
      check("rst_full_valid", 64'(out_valid), 64'h0);
      check("rst_full_data", out_data, 64'h0);
      check("rst_full_err", 64'(err_sel), 64'h0);
      rst = 1'b0;
      drive(0, 2'd0, 0, 16'h0, 4'h0); tick();
      check("rst_no_deliver", 64'(out_valid), 64'h0);

      // Three-channel instance: out-of-range select is dropped and flagged once.
      rst3 = 1'b0; v3 = 1'b1; s3 = 2'd1; d3 = 16'h0111; or3 = 3'b000;
      #1 check("n3_ready_uni", 64'(r3), 64'h1);
      @(posedge clk); #1;
      check("n3_uni_valid", 64'(ov3), 64'h2);
      check("n3_uni_err", 64'(e3), 64'h0);
      s3 = 2'd3; d3 = 16'hDEAD;
      #1 check("n3_bad_ready", 64'(r3), 64'h1);
      @(posedge clk); #1;
      check("n3_err_pulse", 64'(e3), 64'h1);
      check("n3_bad_valid", 64'(ov3), 64'h2);
      check("n3_bad_data", 64'(od3[31:16]), 64'h0111);
      v3 = 1'b0;
      #1 check("n3_ready_novalid", 64'(r3), 64'h1);
      @(posedge clk); #1;
      check("n3_err_clear", 64'(e3), 64'h0);
      check("n3_idle_valid", 64'(ov3), 64'h2);
      v3 = 1'b1; b3 = 1'b1; d3 = 16'h3C3C; or3 = 3'b111;
      @(posedge clk); #1;
      check("n3_bcast_valid", 64'(ov3), 64'h7);
      check("n3_bcast_err", 64'(e3), 64'h0);
      check("n3_bcast_data", 64'(od3), 64'h3C3C_3C3C_3C3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
